// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - two-port SRAM responder with port arbitration and fixed latency (optional MEM_RESP_ROUND_ROBIN_EN)
module mem_port_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        resp_b,
  output logic [31:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    g_port_b;
  logic                    g_write;
  logic [ADDR_WIDTH-1:0]   g_idx;
  logic [31:0]             g_wdata;
  logic [3:0]              g_wmask;
  logic [31:0]             mem [DEPTH];

  logic                    elig_a;
  logic                    elig_b;
  logic                    pick_b;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sel_idx;
  logic                    acc;
  logic                    acc_port_b;
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_wmask;

  // Byte offset and aliasing address bits carry no information here.
  logic unused_addr;
  assign unused_addr = ^{address_a[31:ADDR_WIDTH+2], address_a[1:0],
                         address_b[31:ADDR_WIDTH+2], address_b[1:0]};

`ifdef MEM_RESP_ROUND_ROBIN_EN
  logic last_b;
`endif

  // Arbitration: a port in its resp cycle is skipped so a held request is not accepted twice.
  always_comb begin
    elig_a = read_a && !resp_a;
    elig_b = (read_b || write) && !resp_b;
`ifdef MEM_RESP_ROUND_ROBIN_EN
    pick_b = elig_b && (!elig_a || !last_b);
`else
    pick_b = elig_b;
`endif
    accept  = (state == IDLE) && (elig_a || elig_b);
    sel_idx = pick_b ? address_b[ADDR_WIDTH+1:2] : address_a[ADDR_WIDTH+1:2];
  end

  // Access point: the acceptance cycle is the first latency cycle, so LATENCY=1 accesses on the accept edge.
  always_comb begin
    acc        = 1'b0;
    acc_port_b = 1'b0;
    acc_write  = 1'b0;
    acc_idx    = '0;
    acc_wdata  = '0;
    acc_wmask  = '0;
    if (LATENCY == 1) begin
      acc        = accept;
      acc_port_b = pick_b;
      acc_write  = pick_b && write;
      acc_idx    = sel_idx;
      acc_wdata  = wdata;
      acc_wmask  = wmask;
    end else begin
      acc        = (state == BUSY) && (cnt == 4'd1);
      acc_port_b = g_port_b;
      acc_write  = g_write;
      acc_idx    = g_idx;
      acc_wdata  = g_wdata;
      acc_wmask  = g_wmask;
    end
  end

  // Array write with byte lanes; contents survive reset and nothing lands while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && acc && acc_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered responses and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      resp_a   <= 1'b0;
      resp_b   <= 1'b0;
      rdata_a  <= 32'd0;
      rdata_b  <= 32'd0;
      g_port_b <= 1'b0;
      g_write  <= 1'b0;
      g_idx    <= '0;
      g_wdata  <= 32'd0;
      g_wmask  <= 4'd0;
`ifdef MEM_RESP_ROUND_ROBIN_EN
      last_b   <= 1'b1;
`endif
    end else begin
      resp_a <= 1'b0;
      resp_b <= 1'b0;
      if (acc) begin
        if (acc_port_b) begin
          resp_b  <= 1'b1;
          rdata_b <= acc_write ? 32'd0 : mem[acc_idx];
        end else begin
          resp_a  <= 1'b1;
          rdata_a <= mem[acc_idx];
        end
      end
      case (state)
        IDLE: begin
          if (accept) begin
            g_port_b <= pick_b;
            g_write  <= pick_b && write;
            g_idx    <= sel_idx;
            g_wdata  <= wdata;
            g_wmask  <= wmask;
            cnt      <= 4'(LATENCY - 1);
            state    <= (LATENCY > 1) ? BUSY : IDLE;
`ifdef MEM_RESP_ROUND_ROBIN_EN
            last_b   <= pick_b;
`endif
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// tb/tb_mem_port_responder.sv - directed self-checking bench for mem_port_responder at LATENCY 1, 2 and 3
module tb_mem_port_responder;

  logic        clk;
  logic        rst_n;
  logic        read_a    [3];
  logic [31:0] address_a [3];
  logic        resp_a    [3];
  logic [31:0] rdata_a   [3];
  logic        read_b    [3];
  logic        write     [3];
  logic [31:0] address_b [3];
  logic [31:0] wdata     [3];
  logic [3:0]  wmask     [3];
  logic        resp_b    [3];
  logic [31:0] rdata_b   [3];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance k runs with LATENCY = k+1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_responder #(.ADDR_WIDTH(10), .LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read_a    (read_a[g]),
      .address_a (address_a[g]),
      .resp_a    (resp_a[g]),
      .rdata_a   (rdata_a[g]),
      .read_b    (read_b[g]),
      .write     (write[g]),
      .address_b (address_b[g]),
      .wdata     (wdata[g]),
      .wmask     (wmask[g]),
      .resp_b    (resp_b[g]),
      .rdata_b   (rdata_b[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on instance k, started at a negedge; resp must appear exactly k+1 cycles later.
  task automatic access(input int k, input bit pb, input bit rb, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm,
                        input logic [31:0] exp_rd, input string tag);
    logic r;
    if (pb) begin
      read_b[k] = rb; write[k] = wr; address_b[k] = addr; wdata[k] = wd; wmask[k] = wm;
    end else begin
      read_a[k] = 1'b1; address_a[k] = addr;
    end
    for (int i = 1; i <= k + 1; i++) begin
      @(negedge clk);
      r = pb ? resp_b[k] : resp_a[k];
      check({tag, "_resp"}, 32'(r), 32'(i == k + 1));
    end
    check({tag, "_data"}, pb ? rdata_b[k] : rdata_a[k], exp_rd);
    read_a[k] = 1'b0; read_b[k] = 1'b0; write[k] = 1'b0;
    @(negedge clk);
    r = pb ? resp_b[k] : resp_a[k];
    check({tag, "_clr"}, 32'(r), 32'd0);
  endtask

  // Simultaneous reads on the LATENCY=2 instance: A at 0x10, B at 0x20.
  task automatic tie(input bit b_first, input string tag);
    read_a[1] = 1'b1; address_a[1] = 32'h10;
    read_b[1] = 1'b1; address_b[1] = 32'h20;
    @(negedge clk);
    check({tag, "_a0"}, 32'(resp_a[1]), 32'd0);
    check({tag, "_b0"}, 32'(resp_b[1]), 32'd0);
    @(negedge clk);
    check({tag, "_a1"}, 32'(resp_a[1]), 32'(!b_first));
    check({tag, "_b1"}, 32'(resp_b[1]), 32'(b_first));
    if (b_first) begin
      check({tag, "_bd"}, rdata_b[1], 32'h1122AA44);
      read_b[1] = 1'b0;
    end else begin
      check({tag, "_ad"}, rdata_a[1], 32'hDEADBEEF);
      read_a[1] = 1'b0;
    end
    @(negedge clk);
    check({tag, "_a2"}, 32'(resp_a[1]), 32'd0);
    check({tag, "_b2"}, 32'(resp_b[1]), 32'd0);
    @(negedge clk);
    check({tag, "_a3"}, 32'(resp_a[1]), 32'(b_first));
    check({tag, "_b3"}, 32'(resp_b[1]), 32'(!b_first));
    if (b_first) check({tag, "_ad"}, rdata_a[1], 32'hDEADBEEF);
    else         check({tag, "_bd"}, rdata_b[1], 32'h1122AA44);
    read_a[1] = 1'b0; read_b[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      read_a[k] = 1'b0; address_a[k] = '0; read_b[k] = 1'b0; write[k] = 1'b0;
      address_b[k] = '0; wdata[k] = '0; wmask[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_a", 32'(resp_a[1]), 32'd0);
    check("rst_resp_b", 32'(resp_b[1]), 32'd0);
    check("rst_rdata_a", rdata_a[1], 32'd0);
    check("rst_rdata_b", rdata_b[1], 32'd0);
    rst_n = 1'b1;

    // Full write via B, then read back via A.
    access(1, 1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, "wr_full");
    access(1, 0, 0, 0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, "rd_a");

    // Partial write merges a single lane.
    access(1, 1, 0, 1, 32'h20, 32'h11223344, 4'hF, 32'd0, "pw1");
    access(1, 1, 0, 1, 32'h20, 32'h0000AA00, 4'b0010, 32'd0, "pw2");
    access(1, 1, 1, 0, 32'h20, 32'd0, 4'h0, 32'h1122AA44, "pr");

    // Ties.
`ifdef MEM_RESP_ROUND_ROBIN_EN
    tie(1'b0, "tie1");
    access(1, 0, 0, 0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, "rr_a");
    tie(1'b1, "tie2");
`else
    tie(1'b1, "tie1");
    tie(1'b1, "tie2");
`endif

    // LATENCY=1 with read_a held: resp every second cycle.
    access(0, 1, 0, 1, 32'h10, 32'h0BADF00D, 4'hF, 32'd0, "l1_w");
    read_a[0] = 1'b1; address_a[0] = 32'h10;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("l1_resp%0d", i), 32'(resp_a[0]), 32'(i % 2));
      if (resp_a[0]) check($sformatf("l1_data%0d", i), rdata_a[0], 32'h0BADF00D);
    end
    read_a[0] = 1'b0;
    @(negedge clk);

    // Aliased address with read_b and write both high is a write.
    access(1, 1, 1, 1, 32'h1010, 32'hCAFEF00D, 4'hF, 32'd0, "alias_w");
    access(1, 0, 0, 0, 32'h10, 32'd0, 4'h0, 32'hCAFEF00D, "alias_r");

    // Reset one cycle after a LATENCY=3 write is accepted.
    access(2, 1, 0, 1, 32'h30, 32'h55667788, 4'hF, 32'd0, "l3_w");
    access(2, 1, 1, 0, 32'h30, 32'd0, 4'h0, 32'h55667788, "l3_r");
    write[2] = 1'b1; address_b[2] = 32'h30; wdata[2] = 32'hFFFFFFFF; wmask[2] = 4'hF;
    @(negedge clk);
    check("mid_resp_pre", 32'(resp_b[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata_b", rdata_b[2], 32'd0);
    check("mid_rst_rdata_a", rdata_a[1], 32'd0);
    check("mid_rst_resp_b", 32'(resp_b[2]), 32'd0);
    write[2] = 1'b0;
    @(negedge clk);
    check("mid_rst_resp_b2", 32'(resp_b[2]), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid_noresp%0d", i), 32'(resp_b[2]), 32'd0);
    end
    access(2, 1, 1, 0, 32'h30, 32'd0, 4'h0, 32'h55667788, "mid_old");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
